pipe_buffer_chain: RTL and testbench
====================================

Name: pipe_buffer_chain

Overview:
- Parametrised multi-stage pipeline register chain; successor to the single-stage pipeline buffer.
- Adds per-stage valid tracking, a per-stage hold and flush, backward stall propagation, automatic bubble insertion and an input-ready indication.
- Sits between processor pipeline stages, or wherever a DEPTH-cycle delay line with stall/squash control is needed.
- Stage 0 is the input side; stage DEPTH-1 drives the output.

Parameters:
- N, 32, data width in bits.
- DEPTH, 4, number of register stages (legal 1..8).
- NOP, {N{1'b0}}, data value loaded on reset, flush or bubble.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  DEPTH  per-stage squash; bit i forces stage i to NOP/invalid at the next edge.
- hold  input  DEPTH  per-stage stall request; bit i freezes stage i and every stage upstream of it.
- in_valid  input  1  buffer_in carries a valid item.
- buffer_in  input  N  data into stage 0.
- in_ready  output  1  stage 0 will accept buffer_in this cycle.
- buffer_out  output  N  data of stage DEPTH-1.
- out_valid  output  1  valid bit of stage DEPTH-1.
- stage_valid  output  DEPTH  valid bit of every stage.
- insert_bubble  output  DEPTH  bit i high while stage i is loading a stall bubble this cycle.

Behaviour:
- Effective hold (combinational): eh[DEPTH-1] = hold[DEPTH-1]; eh[i] = hold[i] | eh[i+1].
- in_ready = ~eh[0], combinational.
- Per-stage next-state priority, evaluated independently for each stage at every edge:
  - reset: data = NOP, valid = 0 for all stages.
  - flush[i]: data = NOP, valid = 0. Flush overrides hold. Flushing stage i does not change what stage i+1 captures this edge; stage i+1 takes stage i's pre-edge content unless flush[i+1] is also set.
  - eh[i]: stage i keeps its data and valid.
  - bubble (i > 0, eh[i-1] = 1, eh[i] = 0): data = NOP, valid = 0.
  - advance: stage 0 loads buffer_in and in_valid; stage i > 0 loads stage i-1 data and valid.
- insert_bubble[i] = (i > 0) & eh[i-1] & ~eh[i] & ~flush[i] & ~reset; insert_bubble[0] is always 0.
- Input side: when in_ready = 0, buffer_in is ignored. The source must hold its item until in_ready = 1; the block never stores it.
- Latency: an item accepted at edge k appears on buffer_out after edge k+DEPTH-1, assuming no holds.
- Throughput: one item per cycle with no holds.
- Invalid stages are held like valid ones; a stall never collapses bubbles.
- All hold bits set: the chain is frozen and in_ready = 0.
- Reset asserted mid-stall or mid-flush wins; after reset every stage is NOP/invalid.
- Reset values: buffer_out = NOP, out_valid = 0, stage_valid = 0, insert_bubble = 0, in_ready = ~eh[0] (combinational, not reset-dependent).
- DEPTH = 1: the block is a single register; insert_bubble is constant 0.
- buffer_out and out_valid are driven directly from registers, with no combinational path from any input.

Optional Feature:
- Macro: PIPE_BUFFER_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_count [15:0], a saturating count of cycles in which any insert_bubble bit was high.
  - Adds output flush_count [15:0], a saturating count of cycles in which any flush bit was high.
  - Both counters clear to 0 on reset, stick at 16'hFFFF and never wrap.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: reset=1 for 1 cycle with in_valid=1 and buffer_in=32'hABCDEF12 -> after the edge, stage_valid=4'b0000, buffer_out=0, out_valid=0.
- Streaming (DEPTH=4): feed 32'hABCDEF12, 32'h12345678, 32'h12121212 on consecutive cycles -> buffer_out shows them in order, starting 3 edges after the first capture. out_valid stays high for exactly 3 cycles, then drops to 0.
- Stall: keep streaming and set hold=4'b0100 for 2 cycles -> stages 0-2 frozen, in_ready=0, insert_bubble=4'b1000 for both cycles, stage 3 valid=0 during the bubbles; afterwards the sequence resumes with no item lost or duplicated.
- Partial flush: with all 4 stages valid, pulse flush=4'b0011 for 1 cycle -> stage_valid=4'b1100 after the edge (stages 0-1 NOP, stage 2 holds the old stage-1 item, stage 3 the old stage-2 item).
- Flush vs hold: hold=4'b0010 and flush=4'b0010 together -> stage 1 becomes NOP/invalid, stage 0 holds, in_ready=0, insert_bubble[2]=1.
- Counters (macro defined): 70000 bubble cycles -> bubble_count=16'hFFFF; reset -> 0. With the macro undefined, the bench compiles without the counter ports.

Source files
------------

// File: rtl/pipe_buffer_chain.sv
// rtl/pipe_buffer_chain.sv - DEPTH-stage pipeline register chain with hold, flush and bubbles.
// Optional macro PIPE_BUFFER_BUBBLE_CNT_EN adds saturating bubble/flush cycle counters.
module pipe_buffer_chain #(
   parameter int          N     = 32,
   parameter int          DEPTH = 4,
   parameter logic [N-1:0] NOP  = {N{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DEPTH-1:0] flush,
   input  logic [DEPTH-1:0] hold,
   input  logic             in_valid,
   input  logic [N-1:0]     buffer_in,
   output logic             in_ready,
   output logic [N-1:0]     buffer_out,
   output logic             out_valid,
   output logic [DEPTH-1:0] stage_valid,
   output logic [DEPTH-1:0] insert_bubble
`ifdef PIPE_BUFFER_BUBBLE_CNT_EN
   ,
   output logic [15:0]      bubble_count,
   output logic [15:0]      flush_count
`endif
);

   logic [N-1:0]     r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] w_eh;
   logic [DEPTH-1:0] w_bubble;

   // A stage is effectively held if it or any stage downstream of it holds.
   always_comb begin
      w_eh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_eh[i] = |(hold >> i);
      end
   end

   always_comb begin
      w_bubble = '0;
      for (int i = 1; i < DEPTH; i++) begin
         w_bubble[i] = w_eh[i-1] & ~w_eh[i] & ~flush[i] & ~reset;
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_stage
         always_ff @(posedge clock) begin
            if (reset || flush[g]) begin
               r_data[g]  <= NOP;
               r_valid[g] <= 1'b0;
            end else if (w_eh[g]) begin
               r_data[g]  <= r_data[g];
               r_valid[g] <= r_valid[g];
            end else begin
               if (g == 0) begin
                  r_data[g]  <= buffer_in;
                  r_valid[g] <= in_valid;
               end else begin
                  // Upstream frozen while this stage drains: load a bubble.
                  if (w_eh[(g > 0) ? g-1 : 0]) begin
                     r_data[g]  <= NOP;
                     r_valid[g] <= 1'b0;
                  end else begin
                     r_data[g]  <= r_data[(g > 0) ? g-1 : 0];
                     r_valid[g] <= r_valid[(g > 0) ? g-1 : 0];
                  end
               end
            end
         end
      end
   endgenerate

   assign in_ready      = ~w_eh[0];
   assign buffer_out    = r_data[DEPTH-1];
   assign out_valid     = r_valid[DEPTH-1];
   assign stage_valid   = r_valid;
   assign insert_bubble = w_bubble;

`ifdef PIPE_BUFFER_BUBBLE_CNT_EN
   logic [15:0] r_bubble_cnt;
   logic [15:0] r_flush_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_bubble_cnt <= 16'h0000;
         r_flush_cnt  <= 16'h0000;
      end else begin
         if ((|w_bubble) && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
         end
         if ((|flush) && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign bubble_count = r_bubble_cnt;
   assign flush_count  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_buffer_chain.sv
// tb/tb_pipe_buffer_chain.sv - directed table-driven bench for pipe_buffer_chain (DEPTH=4, N=32).
module tb_pipe_buffer_chain;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  flush;
   logic [3:0]  hold;
   logic        in_valid;
   logic [31:0] buffer_in;
   logic        in_ready;
   logic [31:0] buffer_out;
   logic        out_valid;
   logic [3:0]  stage_valid;
   logic [3:0]  insert_bubble;
`ifdef PIPE_BUFFER_BUBBLE_CNT_EN
   logic [15:0] bubble_count;
   logic [15:0] flush_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   pipe_buffer_chain #(.N(32), .DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .hold         (hold),
      .in_valid     (in_valid),
      .buffer_in    (buffer_in),
      .in_ready     (in_ready),
      .buffer_out   (buffer_out),
      .out_valid    (out_valid),
      .stage_valid  (stage_valid),
      .insert_bubble(insert_bubble)
`ifdef PIPE_BUFFER_BUBBLE_CNT_EN
      ,
      .bubble_count (bubble_count),
      .flush_count  (flush_count)
`endif
   );

   typedef struct {
      logic        rst;
      logic [3:0]  fl;
      logic [3:0]  ho;
      logic        iv;
      logic [31:0] din;
      logic        exp_rdy;
      logic [3:0]  exp_ib;
      logic [3:0]  exp_sv;
      logic [31:0] exp_out;
      logic        exp_ov;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic rst, logic [3:0] fl, logic [3:0] ho, logic iv,
                               logic [31:0] din, logic rdy, logic [3:0] ib,
                               logic [3:0] sv, logic [31:0] dout, logic ov);
      vec_t v;
      v.rst = rst; v.fl = fl; v.ho = ho; v.iv = iv; v.din = din;
      v.exp_rdy = rdy; v.exp_ib = ib; v.exp_sv = sv; v.exp_out = dout; v.exp_ov = ov;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [3:0] fl, input logic [3:0] ho,
                        input logic iv, input logic [31:0] din);
      reset = rst; flush = fl; hold = ho; in_valid = iv; buffer_in = din;
   endtask

   initial begin
      drive(1'b1, 4'b0, 4'b0, 1'b0, 32'h0);

      //         rst fl       ho       iv din           rdy ib       sv       out           ov
      tv.push_back(mk(1, 4'b0000, 4'b0000, 1, 32'hABCDEF12, 1, 4'b0000, 4'b0000, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hABCDEF12, 1, 4'b0000, 4'b0001, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h12345678, 1, 4'b0000, 4'b0011, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h12121212, 1, 4'b0000, 4'b0111, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b1110, 32'hABCDEF12, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b1100, 32'h12345678, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b1000, 32'h12121212, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b0000, 32'h0,        0));
      // stall with hold on stage 2
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hDDDD0004, 1, 4'b0000, 4'b0001, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hEEEE0005, 1, 4'b0000, 4'b0011, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hFFFF0006, 1, 4'b0000, 4'b0111, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0100, 1, 32'h77770007, 0, 4'b1000, 4'b0111, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0100, 1, 32'h77770007, 0, 4'b1000, 4'b0111, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h77770007, 1, 4'b0000, 4'b1111, 32'hDDDD0004, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h88880008, 1, 4'b0000, 4'b1111, 32'hEEEE0005, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h99990009, 1, 4'b0000, 4'b1111, 32'hFFFF0006, 1));
      // partial flush of stages 0-1
      tv.push_back(mk(0, 4'b0011, 4'b0000, 1, 32'hAAAA000A, 1, 4'b0000, 4'b1100, 32'h77770007, 1));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hBBBB000B, 1, 4'b0000, 4'b1001, 32'h88880008, 1));
      // flush and hold on the same stage
      tv.push_back(mk(0, 4'b0010, 4'b0010, 1, 32'hCCCC000C, 0, 4'b0100, 4'b0001, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b0010, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b0100, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        1, 4'b0000, 4'b1000, 32'hBBBB000B, 1));
      // everything held, then reset while held and flushing
      tv.push_back(mk(0, 4'b0000, 4'b1111, 1, 32'hDDDD000D, 0, 4'b0000, 4'b1000, 32'hBBBB000B, 1));
      tv.push_back(mk(1, 4'b0101, 4'b1111, 1, 32'hDDDD000D, 0, 4'b0000, 4'b0000, 32'h0,        0));
      tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hEEEE000E, 1, 4'b0000, 4'b0001, 32'h0,        0));

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clock);
         drive(tv[i].rst, tv[i].fl, tv[i].ho, tv[i].iv, tv[i].din);
         #1;
         chk("in_ready", i, {31'b0, in_ready}, {31'b0, tv[i].exp_rdy});
         chk("insert_bubble", i, {28'b0, insert_bubble}, {28'b0, tv[i].exp_ib});
         @(posedge clock);
         #1;
         chk("stage_valid", i, {28'b0, stage_valid}, {28'b0, tv[i].exp_sv});
         chk("buffer_out", i, buffer_out, tv[i].exp_out);
         chk("out_valid", i, {31'b0, out_valid}, {31'b0, tv[i].exp_ov});
      end

      // latency: item captured at one edge appears after three more edges
      begin
         int edges;
         @(negedge clock);
         drive(1'b1, 4'b0, 4'b0, 1'b0, 32'h0);
         @(negedge clock);
         drive(1'b0, 4'b0, 4'b0, 1'b1, 32'h5A5A1234);
         @(posedge clock);
         @(negedge clock);
         drive(1'b0, 4'b0, 4'b0, 1'b0, 32'h0);
         edges = 0;
         while (!out_valid && edges < 10) begin
            @(posedge clock);
            #1;
            edges++;
         end
         chk("latency_edges", 0, edges, 3);
         chk("latency_data", 0, buffer_out, 32'h5A5A1234);
      end

`ifdef PIPE_BUFFER_BUBBLE_CNT_EN
      @(negedge clock);
      drive(1'b1, 4'b0, 4'b0, 1'b0, 32'h0);
      @(negedge clock);
      drive(1'b0, 4'b0001, 4'b0, 1'b0, 32'h0);
      repeat (3) @(negedge clock);
      drive(1'b0, 4'b0, 4'b0001, 1'b0, 32'h0);
      #1;
      chk("flush_count", 0, {16'b0, flush_count}, 32'd3);
      chk("bubble_count_start", 0, {16'b0, bubble_count}, 32'd0);
      repeat (70000) @(negedge clock);
      #1;
      chk("bubble_count_sat", 0, {16'b0, bubble_count}, 32'h0000FFFF);
      drive(1'b1, 4'b0, 4'b0001, 1'b0, 32'h0);
      @(negedge clock);
      drive(1'b0, 4'b0, 4'b0, 1'b0, 32'h0);
      #1;
      chk("bubble_count_rst", 0, {16'b0, bubble_count}, 32'd0);
      chk("flush_count_rst", 0, {16'b0, flush_count}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
